clk_divider_prog: RTL and testbench
===================================

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter WIDTH, default 16, is the bit width of each channel's counter and divisor.
REQ-002 Parameter NCH, default 2, is the number of independent divider channels (1..8).
REQ-003 Parameter DEF_DIV, default 8192, is the divisor loaded into every channel at reset.
REQ-004 Port clockin, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-006 Port en, input, NCH bits, is the per-channel count enable.
REQ-007 Port load, input, 1 bit, is a one-cycle divisor-load strobe.
REQ-008 Port load_ch, input, max(1,$clog2(NCH)) bits, selects the target channel.
REQ-009 Port load_div, input, WIDTH bits, is the new divisor value.
REQ-010 Port load_hi, input, WIDTH bits, is the new high-time; it is present only with CLK_DIV_DUTY_EN.
REQ-011 Port load_ack, output, NCH bits, is a one-cycle pulse per channel when a loaded divisor takes effect.
REQ-012 Port clockout, output, NCH bits, is the divided clock per channel, registered.
REQ-013 Port tick, output, NCH bits, is a one-cycle pulse per channel at each period start, registered.

Function
REQ-014 Each channel SHALL hold active divisor D, shadow divisor S, pending flag P and counter C, each WIDTH bits.
REQ-015 Effective divisor De SHALL equal max(D,2), so that D=0 or D=1 yields a 2-cycle period.
REQ-016 With en[i]=1, C SHALL increment each cycle and wrap from De-1 to 0; the period is De cycles.
REQ-017 With en[i]=0, C and clockout[i] SHALL hold, and tick[i] SHALL be 0.
REQ-018 tick[i] SHALL be 1 in exactly the cycles where C==0 as the result of an enabled wrap.
REQ-019 clockout[i] SHALL be 1 while C < Hi, where Hi = De>>1 without duty control, so an odd De gives the shorter high phase.
REQ-020 Outputs SHALL be flops decoded from the next-count value, so they are glitch-free and aligned with C in the same cycle.
REQ-021 When load=1 and load_ch<NCH, the design SHALL write S and set P in the next cycle; no stall occurs and load is always accepted.
REQ-022 When load_ch>=NCH, the design SHALL ignore the load and produce no ack.
REQ-023 A second load to a channel with P set SHALL overwrite S; only one ack results.
REQ-024 At the next enabled wrap with P set, D SHALL take the value of S and P SHALL clear, with load_ack[i]=1 in the same cycle as tick[i].
REQ-025 A load arriving in the cycle of a wrap SHALL apply at the following wrap, never mid-period.
REQ-026 Channels SHALL be fully independent; simultaneous wraps and acks on several channels are legal.

Reset
REQ-027 On reset=1, every channel SHALL set C=0, D=DEF_DIV, S=0, P=0 (and H=DEF_DIV>>1 with duty control).
REQ-028 During reset, clockout, tick and load_ack SHALL be 0.
REQ-029 A reset asserted mid-period SHALL abort the period and drop any pending load without an ack.
REQ-030 On the first enabled cycle after reset, the channel SHALL count from C=0.

Configuration
REQ-031 With macro CLK_DIV_DUTY_EN defined, the design SHALL shadow and apply load_hi together with load_div, and Hi = min(H,De).
  - H=0 SHALL hold clockout at 0.
  - H>=De SHALL hold clockout at 1.
REQ-032 Without CLK_DIV_DUTY_EN, the load_hi port and the H register SHALL be absent, and duty SHALL be fixed per REQ-019.

Structure
REQ-033 Shared package clk_div_pkg SHALL hold MAX_NCH=8, the channel-index width function, and the per-channel state record type (C, D, S, P, H).
REQ-034 One sub-module, clk_div_channel, SHALL implement a single channel; the top SHALL decode load_ch and instantiate NCH copies.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
  - Reset, then en=1 on ch0 with DEF_DIV=8: tick every 8 cycles; clockout high for 4 cycles, low for 4.
  - Load ch1 with div=5 mid-period: old period completes; the next period is 5 cycles, high for 2; load_ack[1] coincides with tick[1].
  - Loads of div=3 then div=6 to ch0 before a wrap: single ack; period becomes 6.
  - div=0 and div=1: period 2, clockout toggles each cycle; load_ch=NCH: no ack, no change.
  - en dropped at C=3 for 10 cycles: C, clockout hold, tick=0; resumes from C=4; reset at C=5 with a load pending: no ack, C=0, D=DEF_DIV.
  - With CLK_DIV_DUTY_EN: div=10, hi=3 gives 3 high, 7 low; hi=0 gives always low; hi=12 gives always high.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable multi-channel clock divider.
//   MAX_NCH    : largest supported channel count
//   MAX_WIDTH  : storage width of the per-channel state record fields
//   ch_state_t : per-channel state (counter, active/shadow divisor, pending,
//                and high-time/shadow high-time when CLK_DIV_DUTY_EN is defined)
//   ch_idx_w() : width of the channel-select field for a given channel count
//   eff_div()  : effective divisor, never below 2
// Optional feature macro: CLK_DIV_DUTY_EN (programmable high time).
package clk_div_pkg;

    localparam int MAX_NCH   = 8;
    localparam int MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] cnt_t;

    typedef struct packed {
        cnt_t c;
        cnt_t d;
        cnt_t s;
        logic p;
`ifdef CLK_DIV_DUTY_EN
        cnt_t h;
        cnt_t sh;
`endif
    } ch_state_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2((n > MAX_NCH) ? MAX_NCH : n) : 1;
    endfunction

    // Divisors 0 and 1 both behave as a 2-cycle period.
    function automatic cnt_t eff_div(input cnt_t d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Bus interface of the clock divider.
//   en, load, load_ch, load_div (load_hi with CLK_DIV_DUTY_EN) : master -> slave
//   load_ack, clockout, tick                                  : slave -> master
// Optional feature macro: CLK_DIV_DUTY_EN adds load_hi.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2
) ();

    localparam int LCW = ch_idx_w(NCH);

    logic [NCH-1:0]   en;
    logic             load;
    logic [LCW-1:0]   load_ch;
    logic [WIDTH-1:0] load_div;
`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] load_hi;
`endif
    logic [NCH-1:0]   load_ack;
    logic [NCH-1:0]   clockout;
    logic [NCH-1:0]   tick;

    modport master (
`ifdef CLK_DIV_DUTY_EN
        output load_hi,
`endif
        output en, load, load_ch, load_div,
        input  load_ack, clockout, tick
    );

    modport slave (
`ifdef CLK_DIV_DUTY_EN
        input  load_hi,
`endif
        input  en, load, load_ch, load_div,
        output load_ack, clockout, tick
    );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel.
//   clockin, reset : clock and synchronous active-high reset
//   en             : count enable
//   wr, wr_div     : decoded load strobe and new divisor (wr_hi: new high time,
//                    present only with CLK_DIV_DUTY_EN)
//   load_ack, clockout, tick : registered outputs
// Optional feature macro: CLK_DIV_DUTY_EN.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 8192
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] wr_hi,
`endif
    output logic             load_ack,
    output logic             clockout,
    output logic             tick
);

    // State fields are stored zero-extended; only the low WIDTH bits ever change.
    localparam cnt_t RST_DIV = cnt_t'(WIDTH'(DEF_DIV));
`ifdef CLK_DIV_DUTY_EN
    localparam cnt_t RST_HI  = cnt_t'(WIDTH'(DEF_DIV >> 1));
`endif

    ch_state_t st_r;
    ch_state_t st_s;
    cnt_t      de_s;
    cnt_t      de_n_s;
    cnt_t      hi_s;
    logic      wrap_s;
    logic      apply_s;
    logic      clk_n_s;
    logic      clockout_r;
    logic      tick_r;
    logic      ack_r;

    // Next-state: count, wrap-time divisor swap, shadow load, and output decode
    // from the next count so the outputs line up with the counter.
    always_comb begin
        st_s    = st_r;
        de_s    = eff_div(st_r.d);
        wrap_s  = en && (st_r.c == (de_s - 32'd1));
        apply_s = wrap_s && st_r.p;
        if (apply_s) begin
            st_s.d = st_r.s;
`ifdef CLK_DIV_DUTY_EN
            st_s.h = st_r.sh;
`endif
            st_s.p = 1'b0;
        end else begin
            st_s.d = st_r.d;
        end
        if (en) begin
            st_s.c = wrap_s ? 32'd0 : cnt_t'(WIDTH'(st_r.c + 32'd1));
        end else begin
            st_s.c = st_r.c;
        end
        // A load in the wrap cycle lands after the swap, so it waits a full period.
        if (wr) begin
            st_s.s = cnt_t'(wr_div);
`ifdef CLK_DIV_DUTY_EN
            st_s.sh = cnt_t'(wr_hi);
`endif
            st_s.p = 1'b1;
        end else begin
            st_s.s = st_r.s;
        end
        de_n_s = eff_div(st_s.d);
`ifdef CLK_DIV_DUTY_EN
        hi_s = (st_s.h < de_n_s) ? st_s.h : de_n_s;
`else
        hi_s = de_n_s >> 1;
`endif
        if (en) begin
            clk_n_s = (st_s.c < hi_s);
        end else begin
            clk_n_s = clockout_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clockin) begin
        if (reset) begin
            st_r.c     <= 32'd0;
            st_r.d     <= RST_DIV;
            st_r.s     <= 32'd0;
            st_r.p     <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            st_r.h     <= RST_HI;
            st_r.sh    <= 32'd0;
`endif
            clockout_r <= 1'b0;
            tick_r     <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            st_r       <= st_s;
            clockout_r <= clk_n_s;
            tick_r     <= wrap_s;
            ack_r      <= apply_s;
        end
    end

    assign clockout = clockout_r;
    assign tick     = tick_r;
    assign load_ack = ack_r;

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable multi-channel clock divider (top).
//   clockin : clock, reset : synchronous active-high reset
//   bus     : clk_div_if slave (en, load, load_ch, load_div, [load_hi],
//             load_ack, clockout, tick)
// Parameters: WIDTH, NCH (1..8), DEF_DIV.
// Optional feature macro: CLK_DIV_DUTY_EN (programmable high time via load_hi).
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NCH     = 2,
    parameter int DEF_DIV = 8192
) (
    input  logic     clockin,
    input  logic     reset,
    clk_div_if.slave bus
);

    localparam int LCW = ch_idx_w(NCH);

    logic [NCH-1:0] wr_s;
    logic [NCH-1:0] ack_s;
    logic [NCH-1:0] clk_s;
    logic [NCH-1:0] tick_s;

    // Channel-select decode; indices at or above NCH match no channel.
    always_comb begin
        wr_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.load && (bus.load_ch == LCW'(i))) begin
                wr_s[i] = 1'b1;
            end else begin
                wr_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_channel #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clockin  (clockin),
            .reset    (reset),
            .en       (bus.en[g]),
            .wr       (wr_s[g]),
            .wr_div   (bus.load_div),
`ifdef CLK_DIV_DUTY_EN
            .wr_hi    (bus.load_hi),
`endif
            .load_ack (ack_s[g]),
            .clockout (clk_s[g]),
            .tick     (tick_s[g])
        );
    end

    assign bus.load_ack = ack_s;
    assign bus.clockout = clk_s;
    assign bus.tick     = tick_s;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog (3 channels, DEF_DIV=8).
module tb_clk_divider_prog;
    import clk_div_pkg::*;

    localparam int WIDTH   = 16;
    localparam int NCH     = 3;
    localparam int DEF_DIV = 8;
    localparam int LCW     = ch_idx_w(NCH);

    logic clockin = 1'b0;
    logic reset   = 1'b1;
    always #5 clockin = ~clockin;

    clk_div_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    clk_divider_prog #(.WIDTH(WIDTH), .NCH(NCH), .DEF_DIV(DEF_DIV)) dut (
        .clockin (clockin),
        .reset   (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt [NCH];

    // Reference model: per-channel integers following the divider rules.
    int m_c [NCH];
    int m_d [NCH];
    int m_s [NCH];
    int m_h [NCH];
    int m_sh [NCH];
    bit m_p [NCH];
    logic [NCH-1:0] x_clk, x_tick, x_ack;

    typedef struct {
        int ch;
        int div;
        int hi;
        int per;
        int high;
    } vec_t;
    vec_t tbl [$];

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            int de, hi;
            bit wrap, wr;
            if (reset) begin
                m_c[i] = 0; m_d[i] = DEF_DIV; m_s[i] = 0; m_p[i] = 0;
                m_h[i] = DEF_DIV / 2; m_sh[i] = 0;
                x_clk[i] = 1'b0; x_tick[i] = 1'b0; x_ack[i] = 1'b0;
            end else begin
                de = (m_d[i] < 2) ? 2 : m_d[i];
                wrap = bus.en[i] && (m_c[i] == de - 1);
                wr = bus.load && (int'(bus.load_ch) == i);
                x_tick[i] = wrap;
                x_ack[i] = wrap && m_p[i];
                if (wrap && m_p[i]) begin
                    m_d[i] = m_s[i]; m_h[i] = m_sh[i]; m_p[i] = 0;
                end
                if (bus.en[i]) m_c[i] = wrap ? 0 : m_c[i] + 1;
                if (wr) begin
                    m_s[i] = int'(bus.load_div);
`ifdef CLK_DIV_DUTY_EN
                    m_sh[i] = int'(bus.load_hi);
`endif
                    m_p[i] = 1;
                end
                de = (m_d[i] < 2) ? 2 : m_d[i];
`ifdef CLK_DIV_DUTY_EN
                hi = (m_h[i] < de) ? m_h[i] : de;
`else
                hi = de / 2;
`endif
                if (bus.en[i]) x_clk[i] = (m_c[i] < hi);
            end
        end
    endtask

    task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the edge, DUT sampled on the falling edge.
    task automatic cycle();
        @(posedge clockin);
        model_step();
        @(negedge clockin);
        check_vec("clockout", bus.clockout, x_clk);
        check_vec("tick", bus.tick, x_tick);
        check_vec("load_ack", bus.load_ack, x_ack);
        for (int i = 0; i < NCH; i++) ack_cnt[i] += int'(bus.load_ack[i]);
    endtask

    task automatic do_load(input int ch, input int div, input int hi);
        bus.load = 1'b1;
        bus.load_ch = LCW'(ch);
        bus.load_div = WIDTH'(div);
`ifdef CLK_DIV_DUTY_EN
        bus.load_hi = WIDTH'(hi);
`else
        if (hi < 0) bus.load_div = '0;
`endif
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic wait_tick(input int ch);
        int k = 0;
        while (!bus.tick[ch] && k < 100) begin cycle(); k++; end
        check_int("wait_tick", int'(bus.tick[ch]), 1);
    endtask

    task automatic wait_ack(input int ch, output int k);
        k = 0;
        while (!bus.load_ack[ch] && k < 100) begin cycle(); k++; end
        check_int("wait_ack", int'(bus.load_ack[ch]), 1);
    endtask

    // Period and high count, starting at a tick sample and ending at the next tick.
    task automatic measure(input int ch, output int per, output int high);
        int k = 0;
        wait_tick(ch);
        per = 1;
        high = int'(bus.clockout[ch]);
        cycle();
        while (!bus.tick[ch] && k < 200) begin
            per++;
            high += int'(bus.clockout[ch]);
            cycle();
            k++;
        end
    endtask

    initial begin
        int per, high, k;
        bus.en = '0; bus.load = 1'b0; bus.load_ch = '0; bus.load_div = '0;
`ifdef CLK_DIV_DUTY_EN
        bus.load_hi = '0;
        tbl.push_back('{0, 10, 3, 10, 3});
        tbl.push_back('{0, 10, 0, 10, 0});
        tbl.push_back('{0, 10, 12, 10, 10});
        tbl.push_back('{1, 4, 1, 4, 1});
        tbl.push_back('{2, 1, 1, 2, 1});
`else
        tbl.push_back('{2, 0, 0, 2, 1});
        tbl.push_back('{2, 1, 0, 2, 1});
        tbl.push_back('{0, 7, 0, 7, 3});
        tbl.push_back('{1, 2, 0, 2, 1});
        tbl.push_back('{2, 9, 0, 9, 4});
        tbl.push_back('{0, 4, 0, 4, 2});
`endif
        foreach (ack_cnt[i]) ack_cnt[i] = 0;

        // Reset: all outputs low.
        reset = 1'b1;
        repeat (2) cycle();
        check_vec("reset_clockout", bus.clockout, '0);
        reset = 1'b0;

        // Default divisor on ch0.
        bus.en = 3'b001;
        measure(0, per, high);
        check_int("def_period", per, 8);
        check_int("def_high", high, 4);

        // Mid-period load on ch1: old period finishes, then 5 cycles, 2 high.
        bus.en = 3'b011;
        wait_tick(1);
        cycle(); cycle();
        do_load(1, 5, 2);
        wait_ack(1, k);
        check_int("ch1_old_period_end", k, 5);
        check_int("ack_with_tick", int'(bus.tick[1]), 1);
        measure(1, per, high);
        check_int("ch1_period", per, 5);
        check_int("ch1_high", high, 2);

        // Two loads before a wrap: one ack, last value wins.
        wait_tick(0);
        ack_cnt[0] = 0;
        do_load(0, 3, 1);
        do_load(0, 6, 3);
        wait_ack(0, k);
        measure(0, per, high);
        check_int("overwrite_period", per, 6);
        measure(0, per, high);
        check_int("overwrite_acks", ack_cnt[0], 1);

        // Table of divisor loads.
        bus.en = 3'b111;
        foreach (tbl[n]) begin
            wait_tick(tbl[n].ch);
            do_load(tbl[n].ch, tbl[n].div, tbl[n].hi);
            wait_ack(tbl[n].ch, k);
            measure(tbl[n].ch, per, high);
            check_int("tbl_period", per, tbl[n].per);
            check_int("tbl_high", high, tbl[n].high);
        end

        // Out-of-range channel select: no ack anywhere.
        foreach (ack_cnt[i]) ack_cnt[i] = 0;
        do_load(NCH, 4, 4);
        repeat (30) cycle();
        check_int("bad_ch_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 0);

        // Enable drop at C=3, resume, then reset with a load pending.
        reset = 1'b1; cycle(); reset = 1'b0;
        bus.en = 3'b001;
        wait_tick(0);
        repeat (3) cycle();
        check_int("c3_clockout", int'(bus.clockout[0]), 1);
        bus.en = 3'b000;
        repeat (10) begin
            cycle();
            check_int("hold_clockout", int'(bus.clockout[0]), 1);
        end
        bus.en = 3'b001;
        cycle();
        check_int("resume_c4_clockout", int'(bus.clockout[0]), 0);
        do_load(0, 3, 1);
        reset = 1'b1; cycle(); reset = 1'b0;
        ack_cnt[0] = 0;
        measure(0, per, high);
        check_int("post_reset_period", per, 8);
        check_int("post_reset_acks", ack_cnt[0], 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.en = NCH'($urandom_range(0, 7));
            bus.load = ($urandom_range(0, 3) == 0);
            bus.load_ch = LCW'($urandom_range(0, 3));
            bus.load_div = WIDTH'($urandom_range(0, 12));
`ifdef CLK_DIV_DUTY_EN
            bus.load_hi = WIDTH'($urandom_range(0, 14));
`endif
            cycle();
        end
        reset = 1'b0; bus.load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
